// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback stage: register addresses and the
// result record carried through the multi-cycle result FIFO.
package writeback_arbiter_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t   rd;
    logic [31:0] data;
  } wb_req_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small circular FIFO holding multi-cycle results that lost arbitration.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: payload only, no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: sole driver of the register bank write port. Merges
// execute results with multi-cycle results, tracks pending multi-cycle
// destinations for decode hazards, and bypasses the registered write data.
//
// Handshake: a multi-cycle result transfers in any cycle where
// mc_valid_i && mc_ready_o; an issue reservation transfers in any cycle where
// mc_issue_i && mc_issue_ready_o. Ready never depends on valid.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int MC_FIFO_DEPTH = 2,
  localparam int CW = $clog2(MC_FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exe_we_i,
  input  reg_addr_t   exe_rd_i,
  input  logic [31:0] exe_data_i,
  input  logic        mc_issue_i,
  input  reg_addr_t   mc_issue_rd_i,
  output logic        mc_issue_ready_o,
  input  logic        mc_valid_i,
  input  reg_addr_t   mc_rd_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  input  reg_addr_t   dec_rs1_i,
  input  reg_addr_t   dec_rs2_i,
  input  reg_addr_t   dec_rd_i,
  input  logic [31:0] rf_data1_i,
  input  logic [31:0] rf_data2_i,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic        hazard_o,
  output logic        rf_we_o,
  output reg_addr_t   rf_rd_o,
  output logic [31:0] rf_data_o
);

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  wb_req_t       fifo_head;
  wb_req_t       mc_req;
  logic          mc_keep;
  logic          exe_sel;
  logic          fifo_sel;
  logic          direct_sel;
  logic          fifo_push;
  logic          sel_valid;
  wb_req_t       sel_req;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;

  assign mc_ready_o = !fifo_full;
  // Accepted results aimed at x0 are swallowed here and never queued.
  assign mc_keep    = mc_valid_i && mc_ready_o && (mc_rd_i != REG_ZERO);
  assign mc_req     = '{rd: mc_rd_i, data: mc_data_i};

  wb_fifo #(.DEPTH(MC_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (mc_req),
    .pop       (fifo_sel),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Priority select: execute, then queued multi-cycle, then direct multi-cycle.
  always_comb begin
    exe_sel    = exe_we_i && (exe_rd_i != REG_ZERO);
    fifo_sel   = !exe_sel && !fifo_empty;
    direct_sel = !exe_sel && fifo_empty && mc_keep;
    fifo_push  = mc_keep && !direct_sel;
    sel_valid  = exe_sel || fifo_sel || direct_sel;
    sel_req    = mc_req;
    if (exe_sel) sel_req = '{rd: exe_rd_i, data: exe_data_i};
    else if (fifo_sel) sel_req = fifo_head;
  end

  // Scoreboard update: clear on selection of a multi-cycle result, set on issue (set wins).
  always_comb begin
    pending_nxt = pending;
    if (fifo_sel) pending_nxt[fifo_head.rd] = 1'b0;
    else if (direct_sel) pending_nxt[mc_rd_i] = 1'b0;
    if (mc_issue_i && mc_issue_ready_o && (mc_issue_rd_i != REG_ZERO))
      pending_nxt[mc_issue_rd_i] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  // Registered bank write port; rd/data hold their value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_o   <= 1'b0;
      rf_rd_o   <= REG_ZERO;
      rf_data_o <= '0;
    end else begin
      rf_we_o <= sel_valid;
      if (sel_valid) begin
        rf_rd_o   <= sel_req.rd;
        rf_data_o <= sel_req.data;
      end
    end
  end

  // Issue readiness, decode hazard and operand bypass from the write stage.
  always_comb begin
    mc_issue_ready_o = !pending[mc_issue_rd_i] || (mc_issue_rd_i == REG_ZERO);
    hazard_o = (pending[dec_rs1_i] && (dec_rs1_i != REG_ZERO)) ||
               (pending[dec_rs2_i] && (dec_rs2_i != REG_ZERO)) ||
               (pending[dec_rd_i]  && (dec_rd_i  != REG_ZERO));
    if (dec_rs1_i == REG_ZERO) op1_o = '0;
    else if (rf_we_o && (rf_rd_o == dec_rs1_i)) op1_o = rf_data_o;
    else op1_o = rf_data1_i;
    if (dec_rs2_i == REG_ZERO) op2_o = '0;
    else if (rf_we_o && (rf_rd_o == dec_rs2_i)) op2_o = rf_data_o;
    else op2_o = rf_data2_i;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue/array reference model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int W     = 38;  // {we, rd[4:0], data[31:0]}

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        exe_we_i = 1'b0;
  reg_addr_t   exe_rd_i = '0;
  logic [31:0] exe_data_i = '0;
  logic        mc_issue_i = 1'b0;
  reg_addr_t   mc_issue_rd_i = '0;
  logic        mc_issue_ready_o;
  logic        mc_valid_i = 1'b0;
  reg_addr_t   mc_rd_i = '0;
  logic [31:0] mc_data_i = '0;
  logic        mc_ready_o;
  reg_addr_t   dec_rs1_i = '0;
  reg_addr_t   dec_rs2_i = '0;
  reg_addr_t   dec_rd_i = '0;
  logic [31:0] rf_data1_i = '0;
  logic [31:0] rf_data2_i = '0;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic        hazard_o;
  logic        rf_we_o;
  reg_addr_t   rf_rd_o;
  logic [31:0] rf_data_o;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  writeback_arbiter #(.MC_FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .exe_we_i         (exe_we_i),
    .exe_rd_i         (exe_rd_i),
    .exe_data_i       (exe_data_i),
    .mc_issue_i       (mc_issue_i),
    .mc_issue_rd_i    (mc_issue_rd_i),
    .mc_issue_ready_o (mc_issue_ready_o),
    .mc_valid_i       (mc_valid_i),
    .mc_rd_i          (mc_rd_i),
    .mc_data_i        (mc_data_i),
    .mc_ready_o       (mc_ready_o),
    .dec_rs1_i        (dec_rs1_i),
    .dec_rs2_i        (dec_rs2_i),
    .dec_rd_i         (dec_rd_i),
    .rf_data1_i       (rf_data1_i),
    .rf_data2_i       (rf_data2_i),
    .op1_o            (op1_o),
    .op2_o            (op2_o),
    .hazard_o         (hazard_o),
    .rf_we_o          (rf_we_o),
    .rf_rd_o          (rf_rd_o),
    .rf_data_o        (rf_data_o)
  );

  // reference model state
  logic [36:0]  m_q[$];      // waiting multi-cycle results {rd, data}, arrival order
  logic [31:0]  m_pend;      // destinations with a multi-cycle op in flight
  logic         m_we;        // what the bank write port currently shows
  logic [4:0]   m_rd;
  logic [31:0]  m_data;
  logic [W-1:0] exp_q[$];    // expected write-port contents after each edge

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    exe_we_i = 1'b0; exe_rd_i = '0; exe_data_i = '0;
    mc_issue_i = 1'b0; mc_issue_rd_i = '0;
    mc_valid_i = 1'b0; mc_rd_i = '0; mc_data_i = '0;
    dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0;
    rf_data1_i = 32'hA5A5_0001; rf_data2_i = 32'hA5A5_0002;
  endtask

  task automatic drive_exe(input logic [4:0] rd, input logic [31:0] data);
    exe_we_i = 1'b1; exe_rd_i = rd; exe_data_i = data;
  endtask

  task automatic drive_mc(input logic [4:0] rd, input logic [31:0] data);
    mc_valid_i = 1'b1; mc_rd_i = rd; mc_data_i = data;
  endtask

  task automatic drive_issue(input logic [4:0] rd);
    mc_issue_i = 1'b1; mc_issue_rd_i = rd;
  endtask

  task automatic drive_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2);
    dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd; rf_data1_i = d1; rf_data2_i = d2;
  endtask

  task automatic drive_random();
    exe_we_i      = ($urandom_range(0, 2) == 0);
    exe_rd_i      = 5'($urandom_range(0, 11));
    exe_data_i    = $urandom;
    mc_issue_i    = ($urandom_range(0, 2) == 0);
    mc_issue_rd_i = 5'($urandom_range(0, 11));
    mc_valid_i    = ($urandom_range(0, 1) == 0);
    mc_rd_i       = 5'($urandom_range(0, 11));
    mc_data_i     = $urandom;
    dec_rs1_i     = 5'($urandom_range(0, 11));
    dec_rs2_i     = 5'($urandom_range(0, 11));
    dec_rd_i      = 5'($urandom_range(0, 11));
    rf_data1_i    = $urandom;
    rf_data2_i    = $urandom;
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model by the arbitration rules, then check the registered write port.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    logic         e_ready, e_iss_ready, e_haz, accept_mc;
    logic [31:0]  e_op1, e_op2;
    logic [36:0]  head;
    logic         n_we;
    logic [4:0]   n_rd;
    logic [31:0]  n_data;
    logic [W-1:0] e;
    #1;
    e_ready     = (m_q.size() < DEPTH);
    e_iss_ready = !m_pend[mc_issue_rd_i] || (mc_issue_rd_i == 5'd0);
    e_haz       = (m_pend[dec_rs1_i] && dec_rs1_i != 5'd0) ||
                  (m_pend[dec_rs2_i] && dec_rs2_i != 5'd0) ||
                  (m_pend[dec_rd_i]  && dec_rd_i  != 5'd0);
    e_op1 = (dec_rs1_i == 5'd0) ? 32'd0 : (m_we && m_rd == dec_rs1_i) ? m_data : rf_data1_i;
    e_op2 = (dec_rs2_i == 5'd0) ? 32'd0 : (m_we && m_rd == dec_rs2_i) ? m_data : rf_data2_i;
    check("mc_ready", mc_ready_o, e_ready);
    check("issue_ready", mc_issue_ready_o, e_iss_ready);
    check("hazard", hazard_o, e_haz);
    check("op1", op1_o, e_op1);
    check("op2", op2_o, e_op2);

    accept_mc = mc_valid_i && e_ready && (mc_rd_i != 5'd0);
    n_we = 1'b0; n_rd = m_rd; n_data = m_data;
    if (exe_we_i && exe_rd_i != 5'd0) begin
      n_we = 1'b1; n_rd = exe_rd_i; n_data = exe_data_i;
      if (accept_mc) m_q.push_back({mc_rd_i, mc_data_i});
    end else if (m_q.size() != 0) begin
      head = m_q.pop_front();
      n_we = 1'b1; n_rd = head[36:32]; n_data = head[31:0];
      m_pend[n_rd] = 1'b0;
      if (accept_mc) m_q.push_back({mc_rd_i, mc_data_i});
    end else if (accept_mc) begin
      n_we = 1'b1; n_rd = mc_rd_i; n_data = mc_data_i;
      m_pend[mc_rd_i] = 1'b0;
    end
    if (mc_issue_i && e_iss_ready && mc_issue_rd_i != 5'd0) m_pend[mc_issue_rd_i] = 1'b1;
    exp_q.push_back({n_we, n_rd, n_data});

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", rf_we_o, e[37]);
    if (e[37]) begin
      check("rf_rd", rf_rd_o, e[36:32]);
      check("rf_data", rf_data_o, e[31:0]);
    end
    m_we = e[37]; m_rd = e[36:32]; m_data = e[31:0];
  endtask

  // Reset with a result waiting on the mc port; model state is discarded too.
  task automatic do_reset();
    drive_idle();
    drive_mc(5'd5, 32'h1111_2222);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rf_we", rf_we_o, 1'b0);
    check("rst_rf_rd", rf_rd_o, 5'd0);
    check("rst_rf_data", rf_data_o, 32'd0);
    m_q.delete(); exp_q.delete();
    m_pend = '0; m_we = 1'b0; m_rd = '0; m_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_mc_ready", mc_ready_o, 1'b1);
    check("post_rst_issue_ready", mc_issue_ready_o, 1'b1);
    check("post_rst_rf_we", rf_we_o, 1'b0);
    mc_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rf_we", rf_we_o, 1'b0);
  endtask

  initial begin
    drive_idle();
    do_reset();

    // single multi-cycle result goes straight through
    drive_idle(); drive_mc(5'd5, 32'hDEAD_BEEF); cycle();
    drive_idle(); cycle();

    // execute hogs the port; mc results queue until full, then drain in order
    drive_idle(); drive_exe(5'd3, 32'h0000_0003); drive_mc(5'd7, 32'h0000_0007); cycle();
    drive_idle(); drive_exe(5'd3, 32'h0000_0033); drive_mc(5'd8, 32'h0000_0008); cycle();
    drive_idle(); drive_exe(5'd3, 32'h0000_0333); drive_mc(5'd9, 32'h0000_0009); cycle();
    drive_idle(); cycle();
    drive_idle(); cycle();
    drive_idle(); cycle();

    // reservation, hazard on rs2, rejected double issue, clear on write
    drive_idle(); drive_issue(5'd10); cycle();
    drive_idle(); drive_dec(5'd1, 5'd10, 5'd2, 32'h1, 32'h2); drive_issue(5'd10); cycle();
    drive_idle(); drive_dec(5'd1, 5'd10, 5'd2, 32'h1, 32'h2); drive_mc(5'd10, 32'hCAFE_0010); cycle();
    drive_idle(); drive_dec(5'd1, 5'd10, 5'd2, 32'h1, 32'h2); cycle();

    // bypass from the registered write port, and x0 reads as zero
    drive_idle(); drive_exe(5'd4, 32'h0000_1234); cycle();
    drive_idle(); drive_exe(5'd4, 32'h0000_1234); drive_dec(5'd4, 5'd4, 5'd0, 32'h0, 32'h0); cycle();
    drive_idle(); drive_dec(5'd0, 5'd4, 5'd0, 32'hFFFF_FFFF, 32'h0); cycle();

    // writes to x0 are discarded
    drive_idle(); drive_exe(5'd0, 32'hFFFF_FFFF); cycle();
    drive_idle(); drive_mc(5'd0, 32'hFFFF_FFFF); drive_issue(5'd0); cycle();
    drive_idle(); cycle();

    // randomized traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      drive_random(); cycle();
    end
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive_random(); cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
